// File: rtl/spi_pkg.sv
// Shared SPI definitions: link state encoding, default widths and
// the bit-counter width helper used by the SPI receive path.
package spi_pkg;

    // Frame-level state shared by the SPI link blocks.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1,
        DONE    = 2'd2
    } spi_state_t;

    localparam int DEF_DATA_WIDTH  = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int MIN_SYNC_STAGES = 2;
    localparam int MAX_SYNC_STAGES = 4;

    // Counter must be able to hold the value DATA_WIDTH itself.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for one asynchronous input bit.
// Ports: clk, rst (async active-high), d (async input), q (synced output).
module sync_ff
    import spi_pkg::*;
#(
    parameter int   DEPTH   = DEF_SYNC_STAGES,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [DEPTH-1:0] chain;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {DEPTH{RST_VAL}};
        end else begin
            chain <= {chain[DEPTH-2:0], d};
        end
    end

    assign q = chain[DEPTH-1];

endmodule

// File: rtl/spi_rx.sv
// SPI receiver: deserialises one MSB-first word per select-low frame,
// sampling data on synchronised rising edges of data_clk_in.
// Ports:
//   clk_in       system clock
//   rst_in       async active-high reset
//   data_in      serial data (MOSI), async
//   data_clk_in  serial clock, idles low, async
//   sel_in       chip select, active low, async
//   data_out     last complete received word
//   new_data_out one-cycle strobe when data_out updates
//   frame_err_out one-cycle strobe on a partial-frame abort
//                (only when SPI_RX_FRAME_ERR_EN is defined)
module spi_rx
    import spi_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  data_in,
    input  logic                  data_clk_in,
    input  logic                  sel_in,
    output logic [DATA_WIDTH-1:0] data_out,
`ifdef SPI_RX_FRAME_ERR_EN
    output logic                  frame_err_out,
`endif
    output logic                  new_data_out
);

    localparam int CW = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

    logic data_s;
    logic clk_s;
    logic sel_s;
    logic clk_prev;
    logic rise;

    spi_state_t            state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shreg;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic [DATA_WIDTH-1:0] first_bit;

    // Equal depth on data and clock keeps each sampled bit aligned
    // with the edge that qualifies it.
    sync_ff #(
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_data (
        .clk (clk_in),
        .rst (rst_in),
        .d   (data_in),
        .q   (data_s)
    );

    sync_ff #(
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (1'b0)
    ) u_sync_clk (
        .clk (clk_in),
        .rst (rst_in),
        .d   (data_clk_in),
        .q   (clk_s)
    );

    // Select resets deselected so a reset never fakes a frame start.
    sync_ff #(
        .DEPTH   (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync_sel (
        .clk (clk_in),
        .rst (rst_in),
        .d   (sel_in),
        .q   (sel_s)
    );

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            clk_prev <= 1'b0;
        end else begin
            clk_prev <= clk_s;
        end
    end

    assign rise      = clk_s & ~clk_prev;
    assign shift_nxt = {shreg[DATA_WIDTH-2:0], data_s};
    assign first_bit = {{(DATA_WIDTH-1){1'b0}}, data_s};

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state        <= IDLE;
            cnt          <= '0;
            shreg        <= '0;
            data_out     <= '0;
            new_data_out <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
            frame_err_out <= 1'b0;
`endif
        end else begin
            new_data_out <= 1'b0;
`ifdef SPI_RX_FRAME_ERR_EN
            frame_err_out <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (!sel_s) begin
                        state <= RECEIVE;
                        // A rise coinciding with select counts as bit 0.
                        if (rise) begin
                            cnt   <= CW'(1);
                            shreg <= first_bit;
                        end else begin
                            cnt   <= '0;
                            shreg <= '0;
                        end
                    end
                end
                RECEIVE: begin
                    // Deselect wins over a simultaneous rise.
                    if (sel_s) begin
                        state <= IDLE;
`ifdef SPI_RX_FRAME_ERR_EN
                        frame_err_out <= (cnt != '0);
`endif
                    end else if (rise) begin
                        shreg <= shift_nxt;
                        cnt   <= cnt + 1'b1;
                        if (cnt == LAST_BIT) begin
                            data_out     <= shift_nxt;
                            new_data_out <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Surplus rises in the same frame are dropped here.
                    if (sel_s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
